reg_bank_p: RTL and testbench

REG_BANK_P -- requirements
Module: reg_bank_p

---
 rtl/reg_bank_p.sv | 147 ++++++++++++++
 tb/tb_reg_bank_p.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_p.sv
// reg_bank_p -- parameterised register bank with two registered read ports,
// one write port and a self-initialising fill sequence after reset.
//
// After clear is released the bank fills every entry i with i*INIT_STEP
// (truncated to DATA_W). It takes one entry per clock, so the fill lasts
// DEPTH clocks. busy is high while the fill runs. During the fill the
// read/write ports are ignored and the read outputs hold 0.
//
// Optional feature (macro REG_BANK_BYPASS_EN):
//   defined   - a read of the address being written on the same edge returns
//               writeData (write-to-read forwarding)
//   undefined - such a read returns the entry's value from before the write
//
// Ports:
//   clock      in   single clock, rising edge
//   clear      in   synchronous active-low reset
//   readRegA   in   ADDR_W  read port A address
//   readRegB   in   ADDR_W  read port B address
//   writeReg   in   ADDR_W  write address
//   readWrite  in   1       write enable
//   writeData  in   DATA_W  write data
//   dataReadA  out  DATA_W  registered read data, port A
//   dataReadB  out  DATA_W  registered read data, port B
//   busy       out  1       high while the fill sequence runs
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | fill entry init_ptr with init_ptr*INIT_STEP, ports ignored
// ST_RUN  | normal read/write access
module reg_bank_p #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int INIT_STEP = 2,
    parameter bit ZERO_REG  = 1'b1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [ADDR_W-1:0] readRegA,
    input  logic [ADDR_W-1:0] readRegB,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic              readWrite,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] dataReadA,
    output logic [DATA_W-1:0] dataReadB,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    logic [DATA_W-1:0] rd_a_q, rd_a_d;
    logic [DATA_W-1:0] rd_b_q, rd_b_d;

    // Storage array: no reset, so it can map onto plain RAM.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] init_val;
    logic              wr_is_zero;

    // Truncate the pointer before multiplying. Modular arithmetic keeps the
    // product equal to (i*INIT_STEP) mod 2**DATA_W.
    assign init_val   = DATA_W'(init_ptr_q) * DATA_W'(INIT_STEP);
    assign wr_is_zero = ZERO_REG && (writeReg == '0);

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        rd_a_d     = rd_a_q;
        rd_b_d     = rd_b_q;
        wr_en      = 1'b0;
        wr_addr    = init_ptr_q;
        wr_data    = init_val;

        case (state_q)
            ST_INIT: begin
                wr_en      = 1'b1;
                init_ptr_d = init_ptr_q + ADDR_W'(1);
                rd_a_d     = '0;
                rd_b_d     = '0;
                if (&init_ptr_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                rd_a_d = (ZERO_REG && (readRegA == '0)) ? '0 : mem_q[readRegA];
                rd_b_d = (ZERO_REG && (readRegB == '0)) ? '0 : mem_q[readRegB];
`ifdef REG_BANK_BYPASS_EN
                // Forward the data being written on this edge. Entry 0 stays
                // zero when it is hardwired.
                if (readWrite && (readRegA == writeReg)) begin
                    rd_a_d = wr_is_zero ? '0 : writeData;
                end
                if (readWrite && (readRegB == writeReg)) begin
                    rd_b_d = wr_is_zero ? '0 : writeData;
                end
`endif
                if (readWrite && !wr_is_zero) begin
                    wr_en   = 1'b1;
                    wr_addr = writeReg;
                    wr_data = writeData;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // A reset edge must never touch the array, including any pending write.
        if (!clear) begin
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign dataReadA = rd_a_q;
    assign dataReadB = rd_b_q;
    assign busy      = (state_q == ST_INIT);

endmodule

// File: tb/tb_reg_bank_p.sv
module tb_reg_bank_p;

    // Main instance: default parameters.
    logic        clock;
    logic        clear;
    logic [4:0]  readRegA, readRegB, writeReg;
    logic        readWrite;
    logic [31:0] writeData;
    logic [31:0] dataReadA, dataReadB;
    logic        busy;

    // Small instance: DATA_W=8, ADDR_W=8, INIT_STEP=3, ZERO_REG=0.
    logic        s_clear;
    logic [7:0]  s_ra, s_rb, s_wa;
    logic        s_we;
    logic [7:0]  s_wd;
    logic [7:0]  s_rd_a, s_rd_b;
    logic        s_busy;

`ifdef REG_BANK_BYPASS_EN
    localparam logic [31:0] EXP_SAME_EDGE = 32'h0000_CAFE;
`else
    localparam logic [31:0] EXP_SAME_EDGE = 32'd18;
`endif

    reg_bank_p dut (
        .clock     (clock),
        .clear     (clear),
        .readRegA  (readRegA),
        .readRegB  (readRegB),
        .writeReg  (writeReg),
        .readWrite (readWrite),
        .writeData (writeData),
        .dataReadA (dataReadA),
        .dataReadB (dataReadB),
        .busy      (busy)
    );

    reg_bank_p #(
        .DATA_W    (8),
        .ADDR_W    (8),
        .INIT_STEP (3),
        .ZERO_REG  (1'b0)
    ) dut_s (
        .clock     (clock),
        .clear     (s_clear),
        .readRegA  (s_ra),
        .readRegB  (s_rb),
        .writeReg  (s_wa),
        .readWrite (s_we),
        .writeData (s_wd),
        .dataReadA (s_rd_a),
        .dataReadB (s_rd_b),
        .busy      (s_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard entries: what a given output must show after the next edge.
    typedef struct {
        string       tag;
        int          sel;  // 0 A, 1 B, 2 busy, 3 small A, 4 small B, 5 small busy
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic expect_v(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Advance one clock, then compare every queued expectation.
    task automatic tick();
        exp_t        e;
        logic [31:0] obs;
        @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0:       obs = dataReadA;
                1:       obs = dataReadB;
                2:       obs = {31'b0, busy};
                3:       obs = {24'b0, s_rd_a};
                4:       obs = {24'b0, s_rd_b};
                default: obs = {31'b0, s_busy};
            endcase
            n_assert++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic init_run(input string tag, input int n_edges);
        for (int k = 1; k <= n_edges; k++) begin
            expect_v({tag, "_busy"}, 2, (k < 32) ? 32'd1 : 32'd0);
            expect_v({tag, "_a0"}, 0, 32'd0);
            expect_v({tag, "_b0"}, 1, 32'd0);
            tick();
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [4:0] b,
                      input logic [31:0] ea, input logic [31:0] eb);
        readRegA = a;
        readRegB = b;
        expect_v({tag, "_a"}, 0, ea);
        expect_v({tag, "_b"}, 1, eb);
        tick();
    endtask

    initial begin
        clear = 1'b0; readRegA = '0; readRegB = '0; writeReg = '0;
        readWrite = 1'b0; writeData = '0;
        s_clear = 1'b0; s_ra = '0; s_rb = '0; s_wa = '0; s_we = 1'b0; s_wd = '0;

        // Reset held for two edges.
        for (int k = 0; k < 2; k++) begin
            expect_v("rst_busy", 2, 32'd1);
            expect_v("rst_a", 0, 32'd0);
            expect_v("rst_b", 1, 32'd0);
            tick();
        end

        // Fill with a write attempt and live read addresses that must be ignored.
        clear = 1'b1;
        readWrite = 1'b1; writeReg = 5'd4; writeData = 32'hFF;
        readRegA = 5'd5; readRegB = 5'd31;
        init_run("init1", 32);
        readWrite = 1'b0;

        rd("rd_5_31", 5'd5, 5'd31, 32'd10, 32'd62);
        rd("rd_4_4", 5'd4, 5'd4, 32'd8, 32'd8);

        // Write 0xDEADBEEF to reg 7, read unrelated entries on that edge.
        readWrite = 1'b1; writeReg = 5'd7; writeData = 32'hDEAD_BEEF;
        rd("wr7", 5'd1, 5'd2, 32'd2, 32'd4);
        readWrite = 1'b0;
        rd("rd7", 5'd7, 5'd0, 32'hDEAD_BEEF, 32'd0);

        // Writes to the hardwired zero entry are discarded.
        readWrite = 1'b1; writeReg = 5'd0; writeData = 32'h1234;
        rd("wr0", 5'd0, 5'd0, 32'd0, 32'd0);
        readWrite = 1'b0;
        rd("rd0", 5'd0, 5'd0, 32'd0, 32'd0);

        // Same-edge read and write of reg 9.
        readWrite = 1'b1; writeReg = 5'd9; writeData = 32'hCAFE;
        rd("same9", 5'd9, 5'd9, EXP_SAME_EDGE, EXP_SAME_EDGE);
        readWrite = 1'b0;
        rd("rd9", 5'd9, 5'd9, 32'hCAFE, 32'hCAFE);

        rd("keep", 5'd3, 5'd20, 32'd6, 32'd40);

        // Reset during RUN with a write presented; outputs clear, fill restarts.
        clear = 1'b0;
        readWrite = 1'b1; writeReg = 5'd3; writeData = 32'h77;
        expect_v("runrst_busy", 2, 32'd1);
        expect_v("runrst_a", 0, 32'd0);
        expect_v("runrst_b", 1, 32'd0);
        tick();
        readWrite = 1'b0;

        // Interrupt the fill at cycle 10; a full fill must follow.
        clear = 1'b1;
        init_run("part", 10);
        clear = 1'b0;
        expect_v("midrst_busy", 2, 32'd1);
        expect_v("midrst_a", 0, 32'd0);
        tick();
        clear = 1'b1;
        init_run("init2", 32);

        rd("post_3_7", 5'd3, 5'd7, 32'd6, 32'd14);
        rd("post_9_31", 5'd9, 5'd31, 32'd18, 32'd62);

        // Small configuration.
        expect_v("s_rst_busy", 5, 32'd1);
        tick();
        s_clear = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            expect_v("s_init_busy", 5, (k < 256) ? 32'd1 : 32'd0);
            tick();
        end
        s_ra = 8'd100; s_rb = 8'd255;
        expect_v("s_rd100", 3, 32'h2C);
        expect_v("s_rd255", 4, 32'hFD);
        tick();
        s_ra = 8'd1; s_rb = 8'd0;
        expect_v("s_rd1", 3, 32'd3);
        expect_v("s_rd0_init", 4, 32'd0);
        tick();
        s_we = 1'b1; s_wa = 8'd0; s_wd = 8'h55;
        tick();
        s_we = 1'b0; s_ra = 8'd0; s_rb = 8'd0;
        expect_v("s_rd0_a", 3, 32'h55);
        expect_v("s_rd0_b", 4, 32'h55);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
